// File: rtl/pwr_gate_pkg.sv
// -----------------------------------------------------------------------------
// pwr_gate_pkg
// Shared definitions for the power-gating sequencer: FSM state encoding,
// default sizing constants and the width of the shared phase timer.
// No ports (package).
// -----------------------------------------------------------------------------
package pwr_gate_pkg;

    // Width of the loadable phase timer; STEP_CYC and ISO_CYC must fit in it.
    localparam int TMR_W        = 8;

    localparam int DEF_N_SW     = 4;
    localparam int DEF_STEP_CYC = 8;
    localparam int DEF_ISO_CYC  = 4;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_RAMP_UP = 3'd1,
        ST_ISO_REL = 3'd2,
        ST_ON      = 3'd3,
        ST_ISO_SET = 3'd4,
        ST_RAMP_DN = 3'd5
    } pwr_state_e;

endpackage

// File: rtl/pwr_gate_timer.sv
// -----------------------------------------------------------------------------
// pwr_gate_timer
// 8-bit loadable down-counter. After a load of value L, o_done is high during
// the L-th cycle following the load edge, so a consumer acting on o_done makes
// its change exactly L edges after the load. The count parks at zero.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   i_load       load i_load_val on the next edge (overrides counting)
//   i_load_val   reload value
//   o_done       high in the cycle whose closing edge ends the interval
// -----------------------------------------------------------------------------
module pwr_gate_timer
    import pwr_gate_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [TMR_W-1:0] i_load_val,
    output logic             o_done
);

    logic [TMR_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - TMR_W'(1);
        end
    end

    assign o_done = (r_count == TMR_W'(1));

endmodule

// File: rtl/pwr_gate_seq.sv
// -----------------------------------------------------------------------------
// pwr_gate_seq
// Power-gating sequencer for a switched domain. Closes the PMOS header
// segments one at a time (LSB first) on power-up, releases the domain reset,
// then drops isolation; power-down runs the reverse order. A single shared
// timer paces both the segment steps and the isolation settle phases.
// Parameters: N_SW (1..16), STEP_CYC (1..255), ISO_CYC (1..255).
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   pwr_req       level request, 1 = domain on
//   pwr_ack       1 only while the domain is fully on and released
//   sw_en_n       header gate drives, 0 = segment conducting
//   iso_en        1 = domain outputs clamped
//   rst_dom_n     active-low reset to the gated domain
//   busy          1 while sequencing (any state other than OFF and ON)
// Optional build macro PWR_GATE_RETENTION_EN adds:
//   ret_save      one-cycle pulse on the second cycle of ISO_SET
//   ret_restore   one-cycle pulse on the second cycle of ISO_REL
// All outputs are registered.
// -----------------------------------------------------------------------------
module pwr_gate_seq
    import pwr_gate_pkg::*;
#(
    parameter int N_SW     = DEF_N_SW,
    parameter int STEP_CYC = DEF_STEP_CYC,
    parameter int ISO_CYC  = DEF_ISO_CYC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pwr_req,
    output logic            pwr_ack,
    output logic [N_SW-1:0] sw_en_n,
    output logic            iso_en,
    output logic            rst_dom_n,
    output logic            busy
`ifdef PWR_GATE_RETENTION_EN
    ,
    output logic            ret_save,
    output logic            ret_restore
`endif
);

    localparam int               CNT_W    = $clog2(N_SW + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(N_SW);
    localparam logic [TMR_W-1:0] STEP_VAL = TMR_W'(STEP_CYC);
    localparam logic [TMR_W-1:0] ISO_VAL  = TMR_W'(ISO_CYC);

    pwr_state_e       r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             r_armed;
    logic             w_req;
    logic             w_load;
    logic [TMR_W-1:0] w_load_val;
    logic             w_done;

    logic [N_SW-1:0]  r_sw_en_n, w_sw_en_n_next;
    logic             r_iso_en, w_iso_en_next;
    logic             r_rst_dom_n, w_rst_dom_n_next;
    logic             r_pwr_ack, w_pwr_ack_next;
    logic             r_busy, w_busy_next;

    // The first edge after reset release only arms the block, so the request
    // is first acted on at the second edge.
    assign w_req = pwr_req & r_armed;

    pwr_gate_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_done)
    );

    // State register (state, segment count and all registered outputs)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_OFF;
            r_cnt       <= '0;
            r_armed     <= 1'b0;
            r_sw_en_n   <= '1;
            r_iso_en    <= 1'b1;
            r_rst_dom_n <= 1'b0;
            r_pwr_ack   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_armed     <= 1'b1;
            r_sw_en_n   <= w_sw_en_n_next;
            r_iso_en    <= w_iso_en_next;
            r_rst_dom_n <= w_rst_dom_n_next;
            r_pwr_ack   <= w_pwr_ack_next;
            r_busy      <= w_busy_next;
        end
    end

    // Next-state logic. A request change always wins over a timer expiry in
    // the same cycle, and every direction change restarts the step window, so
    // the segment count never moves twice within one STEP_CYC window.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_load       = 1'b0;
        w_load_val   = STEP_VAL;
        unique case (r_state)
            ST_OFF: begin
                if (w_req) begin
                    w_state_next = ST_RAMP_UP;
                    w_cnt_next   = CNT_W'(1);
                    w_load       = 1'b1;
                end
            end
            ST_RAMP_UP: begin
                if (!w_req) begin
                    w_state_next = ST_RAMP_DN;
                    w_load       = 1'b1;
                end else if (w_done) begin
                    w_load = 1'b1;
                    if (r_cnt == CNT_MAX) begin
                        // all segments closed and settled for one step
                        w_state_next = ST_ISO_REL;
                        w_load_val   = ISO_VAL;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
            end
            ST_ISO_REL: begin
                if (!w_req) begin
                    w_state_next = ST_ISO_SET;
                    w_load       = 1'b1;
                    w_load_val   = ISO_VAL;
                end else if (w_done) begin
                    w_state_next = ST_ON;
                end
            end
            ST_ON: begin
                if (!w_req) begin
                    w_state_next = ST_ISO_SET;
                    w_load       = 1'b1;
                    w_load_val   = ISO_VAL;
                end
            end
            ST_ISO_SET: begin
                // a new request is deliberately ignored here: the domain must
                // be fully ramped down before it can come back up
                if (w_done) begin
                    w_state_next = ST_RAMP_DN;
                    w_load       = 1'b1;
                end
            end
            ST_RAMP_DN: begin
                if (w_req) begin
                    w_state_next = ST_RAMP_UP;
                    w_load       = 1'b1;
                end else if (w_done) begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_next = ST_OFF;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = ST_OFF;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Output logic: outputs follow the next state so they change on the same
    // edge as the state they describe.
    always_comb begin
        w_iso_en_next    = (w_state_next != ST_ON);
        w_pwr_ack_next   = (w_state_next == ST_ON);
        w_busy_next      = (w_state_next != ST_OFF) && (w_state_next != ST_ON);
        w_rst_dom_n_next = (w_state_next == ST_ISO_REL) ||
                           (w_state_next == ST_ON)      ||
                           (w_state_next == ST_ISO_SET);
    end

    // Segment k conducts exactly when k < cnt.
    for (genvar gi = 0; gi < N_SW; gi++) begin : g_sw
        assign w_sw_en_n_next[gi] = ~(w_cnt_next > CNT_W'(gi));
    end

    assign sw_en_n   = r_sw_en_n;
    assign iso_en    = r_iso_en;
    assign rst_dom_n = r_rst_dom_n;
    assign pwr_ack   = r_pwr_ack;
    assign busy      = r_busy;

`ifdef PWR_GATE_RETENTION_EN
    logic r_first;
    logic r_ret_save;
    logic r_ret_restore;

    // r_first marks the first cycle spent in a state, so the pulse lands on
    // the second cycle of the isolation phase, while clamps are already on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_first       <= 1'b0;
            r_ret_save    <= 1'b0;
            r_ret_restore <= 1'b0;
        end else begin
            r_first       <= (w_state_next != r_state);
            r_ret_save    <= (r_state == ST_ISO_SET) && r_first;
            r_ret_restore <= (r_state == ST_ISO_REL) && r_first;
        end
    end

    assign ret_save    = r_ret_save;
    assign ret_restore = r_ret_restore;
`endif

endmodule

// File: tb/tb_pwr_gate_seq.sv
// -----------------------------------------------------------------------------
// tb_pwr_gate_seq
// Self-checking bench for pwr_gate_seq with default sizing. A behavioural
// model tracks the phase, the segment count and the absolute cycle at which
// the next timed event is due; every cycle all outputs are compared against
// it. Directed steps pin the cycle numbers of the documented scenarios, then
// random request patterns exercise aborts in every phase.
// -----------------------------------------------------------------------------
module tb_pwr_gate_seq;

    localparam int N    = 4;
    localparam int STEP = 8;
    localparam int ISO  = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         pwr_req;
    logic         pwr_ack;
    logic [N-1:0] sw_en_n;
    logic         iso_en;
    logic         rst_dom_n;
    logic         busy;
`ifdef PWR_GATE_RETENTION_EN
    logic         ret_save;
    logic         ret_restore;
`endif

    pwr_gate_seq #(
        .N_SW     (N),
        .STEP_CYC (STEP),
        .ISO_CYC  (ISO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pwr_req   (pwr_req),
        .pwr_ack   (pwr_ack),
        .sw_en_n   (sw_en_n),
        .iso_en    (iso_en),
        .rst_dom_n (rst_dom_n),
        .busy      (busy)
`ifdef PWR_GATE_RETENTION_EN
        ,
        .ret_save    (ret_save),
        .ret_restore (ret_restore)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model
    localparam int M_OFF = 0, M_UP = 1, M_IREL = 2, M_ON = 3, M_ISET = 4, M_DN = 5;
    int m_ph;
    int m_cnt;
    int m_due;
    int m_cyc = 0;
    bit m_armed;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mdl_reset();
        m_ph    = M_OFF;
        m_cnt   = 0;
        m_due   = 0;
        m_armed = 1'b0;
    endtask

    // One rising edge with the request value seen at that edge.
    task automatic mdl_edge(input logic req);
        m_cyc++;
        if (!m_armed) begin
            m_armed = 1'b1;
        end else begin
            case (m_ph)
                M_OFF: if (req) begin
                    m_ph = M_UP; m_cnt = 1; m_due = m_cyc + STEP;
                end
                M_UP: if (!req) begin
                    m_ph = M_DN; m_due = m_cyc + STEP;
                end else if (m_cyc == m_due) begin
                    if (m_cnt < N) begin
                        m_cnt++; m_due = m_cyc + STEP;
                    end else begin
                        m_ph = M_IREL; m_due = m_cyc + ISO;
                    end
                end
                M_IREL: if (!req) begin
                    m_ph = M_ISET; m_due = m_cyc + ISO;
                end else if (m_cyc == m_due) begin
                    m_ph = M_ON;
                end
                M_ON: if (!req) begin
                    m_ph = M_ISET; m_due = m_cyc + ISO;
                end
                M_ISET: if (m_cyc == m_due) begin
                    m_ph = M_DN; m_due = m_cyc + STEP;
                end
                M_DN: if (req) begin
                    m_ph = M_UP; m_due = m_cyc + STEP;
                end else if (m_cyc == m_due) begin
                    m_cnt--;
                    if (m_cnt == 0) m_ph = M_OFF;
                    else            m_due = m_cyc + STEP;
                end
                default: m_ph = M_OFF;
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        logic [N-1:0] e_sw;
        e_sw = {N{1'b1}} << m_cnt;
        chk({tag, "/sw_en_n"},   32'(sw_en_n),   32'(e_sw));
        chk({tag, "/iso_en"},    32'(iso_en),    32'(m_ph != M_ON));
        chk({tag, "/pwr_ack"},   32'(pwr_ack),   32'(m_ph == M_ON));
        chk({tag, "/rst_dom_n"}, 32'(rst_dom_n),
            32'((m_ph == M_IREL) || (m_ph == M_ON) || (m_ph == M_ISET)));
        chk({tag, "/busy"},      32'(busy),      32'((m_ph != M_OFF) && (m_ph != M_ON)));
`ifdef PWR_GATE_RETENTION_EN
        chk({tag, "/ret_iso"},   32'((ret_save | ret_restore) & ~iso_en), 32'(0));
`endif
    endtask

    // Called at a falling edge: drive, take one rising edge, check at the next
    // falling edge.
    task automatic step(input logic req, input string tag);
        pwr_req = req;
        @(posedge clk);
        mdl_edge(req);
        @(negedge clk);
        check_all(tag);
    endtask

    logic r_req;
    int   r_len;

    initial begin
        rst_n   = 1'b0;
        pwr_req = 1'b0;
        mdl_reset();
        @(negedge clk);
        @(negedge clk);
        check_all("reset");
        chk("reset/sw_lit", 32'(sw_en_n), 32'(4'b1111));
        rst_n = 1'b1;

        // Power-up from OFF with cycle numbers measured from the request
        step(1'b0, "arm");
        for (int c = 1; c <= 40; c++) begin
            step(1'b1, "up");
            case (c)
                1:  chk("up_c1_sw",  32'(sw_en_n), 32'(4'b1110));
                8:  chk("up_c8_sw",  32'(sw_en_n), 32'(4'b1110));
                9:  chk("up_c9_sw",  32'(sw_en_n), 32'(4'b1100));
                17: chk("up_c17_sw", 32'(sw_en_n), 32'(4'b1000));
                25: chk("up_c25_sw", 32'(sw_en_n), 32'(4'b0000));
                32: chk("up_c32_rst", 32'(rst_dom_n), 32'(0));
                33: chk("up_c33_rst", 32'(rst_dom_n), 32'(1));
                36: chk("up_c36_ack", 32'(pwr_ack), 32'(0));
                37: begin
                    chk("up_c37_ack",  32'(pwr_ack), 32'(1));
                    chk("up_c37_iso",  32'(iso_en),  32'(0));
                    chk("up_c37_busy", 32'(busy),    32'(0));
                end
                default: ;
            endcase
        end

        // Power-down from ON
        for (int d = 1; d <= 40; d++) begin
            step(1'b0, "dn");
            case (d)
                1: begin
                    chk("dn_d1_iso", 32'(iso_en),  32'(1));
                    chk("dn_d1_ack", 32'(pwr_ack), 32'(0));
                end
                4:  chk("dn_d4_rst",  32'(rst_dom_n), 32'(1));
                5:  chk("dn_d5_rst",  32'(rst_dom_n), 32'(0));
                12: chk("dn_d12_sw",  32'(sw_en_n), 32'(4'b0000));
                13: chk("dn_d13_sw",  32'(sw_en_n), 32'(4'b1000));
                21: chk("dn_d21_sw",  32'(sw_en_n), 32'(4'b1100));
                29: chk("dn_d29_sw",  32'(sw_en_n), 32'(4'b1110));
                36: chk("dn_d36_busy", 32'(busy), 32'(1));
                37: begin
                    chk("dn_d37_sw",   32'(sw_en_n), 32'(4'b1111));
                    chk("dn_d37_busy", 32'(busy),    32'(0));
                end
                default: ;
            endcase
        end

        // Request dropped in RAMP_UP at cnt=2
        for (int c = 1; c <= 30; c++) begin
            step(c <= 11, "abort_up");
            chk("abort_up_iso", 32'(iso_en), 32'(1));
            case (c)
                12: chk("abort_c12_sw", 32'(sw_en_n), 32'(4'b1100));
                19: chk("abort_c19_sw", 32'(sw_en_n), 32'(4'b1100));
                20: chk("abort_c20_sw", 32'(sw_en_n), 32'(4'b1110));
                27: chk("abort_c27_sw", 32'(sw_en_n), 32'(4'b1110));
                28: begin
                    chk("abort_c28_sw",   32'(sw_en_n), 32'(4'b1111));
                    chk("abort_c28_busy", 32'(busy),    32'(0));
                end
                default: ;
            endcase
        end

        // Sub-cycle glitch on the request while OFF
        pwr_req = 1'b1;
        #2;
        pwr_req = 1'b0;
        @(posedge clk);
        mdl_edge(1'b0);
        @(negedge clk);
        check_all("glitch");
        chk("glitch_busy", 32'(busy), 32'(0));

        // Request re-raised during RAMP_DN at cnt=3
        for (int c = 1; c <= 40; c++) step(1'b1, "up2");
        for (int d = 1; d <= 40; d++) begin
            step(d >= 14, "reup");
            case (d)
                13: chk("reup_d13_sw", 32'(sw_en_n), 32'(4'b1000));
                14: begin
                    chk("reup_d14_sw",   32'(sw_en_n), 32'(4'b1000));
                    chk("reup_d14_busy", 32'(busy),    32'(1));
                end
                21: chk("reup_d21_sw",  32'(sw_en_n), 32'(4'b1000));
                22: chk("reup_d22_sw",  32'(sw_en_n), 32'(4'b0000));
                33: chk("reup_d33_ack", 32'(pwr_ack), 32'(0));
                34: chk("reup_d34_ack", 32'(pwr_ack), 32'(1));
                default: ;
            endcase
        end

        // Random request levels and hold times
        for (int i = 0; i < 60; i++) begin
            r_req = 1'($urandom_range(0, 1));
            r_len = $urandom_range(1, 45);
            for (int j = 0; j < r_len; j++) step(r_req, "rnd");
        end
        for (int j = 0; j < 60; j++) step(1'b0, "drain");

        // Asynchronous reset in the middle of RAMP_UP
        for (int c = 1; c <= 12; c++) step(1'b1, "pre_rst");
        rst_n = 1'b0;
        #1;
        chk("arst_sw",   32'(sw_en_n),   32'(4'b1111));
        chk("arst_iso",  32'(iso_en),    32'(1));
        chk("arst_rst",  32'(rst_dom_n), 32'(0));
        chk("arst_ack",  32'(pwr_ack),   32'(0));
        chk("arst_busy", 32'(busy),      32'(0));
        mdl_reset();
        @(negedge clk);
        check_all("in_rst");
        rst_n = 1'b1;
        step(1'b1, "post_rst1");
        chk("post_rst1_sw", 32'(sw_en_n), 32'(4'b1111));
        step(1'b1, "post_rst2");
        chk("post_rst2_sw", 32'(sw_en_n), 32'(4'b1110));
        for (int c = 0; c < 10; c++) step(1'b1, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pwr_gate_seq.md
PWR_GATE_SEQ -- requirements
Module: pwr_gate_seq

Interface
REQ-001 The block SHALL have parameter N_SW, default 4: number of header-switch segments (PMOS sleep transistors) feeding the gated switch-level cell array; legal range 1..16.
REQ-002 The block SHALL have parameter STEP_CYC, default 8: clk cycles between successive segment changes; legal range 1..255.
REQ-003 The block SHALL have parameter ISO_CYC, default 4: clk cycles the isolation/reset settle phase lasts; legal range 1..255.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port pwr_req, input, 1 bit: level request; 1 = domain on, 0 = domain off.
REQ-007 The block SHALL have port pwr_ack, output, 1 bit: 1 only while the domain is fully on and released.
REQ-008 The block SHALL have port sw_en_n, output, N_SW bits: PMOS header gate drives; 0 = segment conducting.
REQ-009 The block SHALL have port iso_en, output, 1 bit: 1 = domain outputs clamped.
REQ-010 The block SHALL have port rst_dom_n, output, 1 bit: active-low reset to the gated domain.
REQ-011 The block SHALL have port busy, output, 1 bit: 1 in any state other than OFF and ON.

Function
REQ-012 The block SHALL implement FSM states OFF, RAMP_UP, ISO_REL, ON, ISO_SET and RAMP_DN; all outputs SHALL be registered.
REQ-013 The block SHALL keep an up/down segment count cnt (0..N_SW) and drive sw_en_n[k]=0 exactly when k<cnt; bits therefore close LSB-first and open MSB-first.
REQ-014 In OFF with pwr_req=1, the FSM SHALL enter RAMP_UP and set cnt=1 on the next edge.
REQ-015 In RAMP_UP, cnt SHALL increment every STEP_CYC cycles until cnt=N_SW.
REQ-016 After cnt reaches N_SW and a further STEP_CYC cycles elapse, the FSM SHALL enter ISO_REL with rst_dom_n=1.
REQ-017 After ISO_CYC cycles in ISO_REL, the FSM SHALL enter ON with iso_en=0 and pwr_ack=1 on the same edge.
REQ-018 In ON with pwr_req=0, the FSM SHALL enter ISO_SET with iso_en=1 and pwr_ack=0 on the next edge.
REQ-019 After ISO_CYC cycles in ISO_SET, the FSM SHALL enter RAMP_DN with rst_dom_n=0.
REQ-020 In RAMP_DN, cnt SHALL decrement every STEP_CYC cycles, the first decrement occurring STEP_CYC cycles after entry; when cnt reaches 0 the FSM SHALL return to OFF with busy=0.
REQ-021 With defaults and pwr_req rising at cycle 0, cnt SHALL be 1/2/3/4 at cycles 1/9/17/25, rst_dom_n SHALL rise at 33, and pwr_ack plus iso_en=0 SHALL occur at 37.
REQ-022 When pwr_req falls in RAMP_UP, the FSM SHALL go to RAMP_DN keeping the current cnt, with the step timer restarted and iso_en and rst_dom_n unchanged (1 and 0).
REQ-023 When pwr_req rises in RAMP_DN, the FSM SHALL go to RAMP_UP keeping the current cnt, with the step timer restarted.
REQ-024 When pwr_req falls in ISO_REL, the FSM SHALL go to ISO_SET with the timer restarted; when pwr_req rises in ISO_SET, the FSM SHALL complete ISO_SET and RAMP_DN before re-ramping.
REQ-025 Glitches on pwr_req shorter than one cycle SHALL have no effect; the block SHALL make at most one segment change per STEP_CYC window.

Reset
REQ-026 While rst_n=0, the block SHALL immediately force state=OFF, cnt=0, sw_en_n=all 1, iso_en=1, rst_dom_n=0, pwr_ack=0, busy=0 and timer=0, including mid-ramp.
REQ-027 After rst_n deasserts, pwr_req SHALL first be sampled on the second rising clk edge.

Configuration
REQ-028 When macro PWR_GATE_RETENTION_EN is defined, the block SHALL add output ports ret_save and ret_restore.
REQ-029 With PWR_GATE_RETENTION_EN defined, ret_save SHALL pulse for one cycle on the second cycle of ISO_SET.
REQ-030 With PWR_GATE_RETENTION_EN defined, ret_restore SHALL pulse for one cycle on the second cycle of ISO_REL.
REQ-031 When PWR_GATE_RETENTION_EN is undefined, the ports SHALL be absent and all other timing SHALL be identical.

Structure
REQ-032 Shared package pwr_gate_pkg SHALL hold the state enum, the default constants for N_SW, STEP_CYC and ISO_CYC, and the 8-bit timer width.
REQ-033 The block SHALL contain one sub-module, pwr_gate_timer, an 8-bit loadable down-counter with a done pulse, instantiated once and reused for the step and ISO phases.

Verification
REQ-034 Scenario: reset, then pwr_req=1 with defaults -> cnt edges at cycles 1/9/17/25, rst_dom_n=1 at 33, pwr_ack=1 and iso_en=0 at 37, busy=0 from 37.
REQ-035 Scenario: from ON, pwr_req=0 -> iso_en=1 and pwr_ack=0 next cycle, rst_dom_n=0 at +5, sw_en_n steps 0000->1000->1100->1110->1111 every 8 cycles, then OFF.
REQ-036 Scenario: pwr_req drops at cycle 12 of RAMP_UP (cnt=2) -> RAMP_DN, cnt=1 at 20, cnt=0 at 28, iso_en never 0.
REQ-037 Scenario: pwr_req re-raised while RAMP_DN cnt=3 -> RAMP_UP, cnt=4 after 8 cycles, pwr_ack after a further 8+4.
REQ-038 Scenario: rst_n pulsed low mid-RAMP_UP -> sw_en_n=1111, iso_en=1 and rst_dom_n=0 asynchronously, before the next clk edge.
REQ-039 Scenario: with PWR_GATE_RETENTION_EN defined -> exactly one ret_save per power-down and one ret_restore per power-up, each while iso_en=1.
